// File: rtl/hazard_ctrl_pkg.sv
// Shared types and compare helpers for the pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_t;

    typedef logic [1:0] md_state_t;

    localparam md_state_t MD_IDLE = 2'd0;
    localparam md_state_t MD_BUSY = 2'd1;
    localparam md_state_t MD_DONE = 2'd2;

    // A producer only counts when it really writes a register other than $0.
    function automatic logic reg_hit(
        input logic [4:0] src,
        input logic [4:0] dst,
        input logic       we
    );
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    function automatic fwd_t fwd_sel(
        input logic [4:0] src,
        input logic [4:0] dst_m,
        input logic       we_m,
        input logic [4:0] dst_w,
        input logic       we_w
    );
        if (reg_hit(src, dst_m, we_m))
            return FWD_M;
        else if (reg_hit(src, dst_w, we_w))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational forwarding selects for the D-stage compare and the E-stage operands.
module hazard_ctrl_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    fwd_t w_fwd_ae;
    fwd_t w_fwd_be;

    assign ForwardAD = reg_hit(RsD, WriteRegM, RegWriteM);
    assign ForwardBD = reg_hit(RtD, WriteRegM, RegWriteM);

    // M is younger than W, so it wins when both target the same register.
    assign w_fwd_ae = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
    assign w_fwd_be = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);

    assign ForwardAE = w_fwd_ae;
    assign ForwardBE = w_fwd_be;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding sequencer for the 5-stage pipeline, including the
// mul/div occupancy FSM that holds E for MULDIV_LAT cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 32
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       MulDivE,
    input  logic       IWaitF,
    input  logic       DWaitM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushE,
    output logic       FlushM,
    output logic       FlushW,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MulDivBusy
);

    localparam int CNT_W = $clog2(MULDIV_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 2);

    md_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    md_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic w_lwstall;
    logic w_brstall;
    logic w_mdstall;
    logic w_memwait;
    logic w_stall_e;

    hazard_ctrl_fwd_unit u_fwd (
        .RsD       (RsD),
        .RtD       (RtD),
        .RsE       (RsE),
        .RtE       (RtE),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE)
    );

    assign w_lwstall = MemtoRegE && (WriteRegE != 5'd0) &&
                       ((WriteRegE == RsD) || (WriteRegE == RtD));

    assign w_brstall = BranchD &&
        ((RegWriteE && (WriteRegE != 5'd0) &&
          ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
         (MemtoRegM && (WriteRegM != 5'd0) &&
          ((WriteRegM == RsD) || (WriteRegM == RtD))));

    // Stall drops in the last BUSY cycle so E advances on the MULDIV_LAT-th cycle.
    assign w_mdstall = MulDivE && !reset &&
                       ((r_state == MD_IDLE) ||
                        ((r_state == MD_BUSY) && (r_cnt != '0)));

    assign w_memwait = IWaitF || DWaitM;
    assign w_stall_e = StallE;

    assign MulDivBusy = (r_state == MD_BUSY);

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        FlushW = 1'b0;
        if (w_memwait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (w_mdstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else if (w_lwstall || w_brstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // The counter keeps running under memwait; DONE blocks a restart of the held op.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            MD_IDLE: begin
                if (MulDivE && !w_memwait) begin
                    w_state_nxt = MD_BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (r_cnt == '0)
                    w_state_nxt = MD_DONE;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            MD_DONE: begin
                if (!w_stall_e)
                    w_state_nxt = MD_IDLE;
            end
            default: begin
                w_state_nxt = MD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MULDIV_LAT=4; expected control vectors
// are queued as each step is driven and compared once the outputs settle.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] RsD, RtD, RsE, RtE;
    logic [4:0] WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic       MemtoRegE, MemtoRegM;
    logic       BranchD, MulDivE, IWaitF, DWaitM;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushE, FlushM, FlushW;
    logic       ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MulDivBusy;

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_q[$];
    string       tag_q[$];
    logic [13:0] obs;

    hazard_ctrl #(.MULDIV_LAT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .RsD        (RsD),
        .RtD        (RtD),
        .RsE        (RsE),
        .RtE        (RtE),
        .WriteRegE  (WriteRegE),
        .WriteRegM  (WriteRegM),
        .WriteRegW  (WriteRegW),
        .RegWriteE  (RegWriteE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .MemtoRegE  (MemtoRegE),
        .MemtoRegM  (MemtoRegM),
        .BranchD    (BranchD),
        .MulDivE    (MulDivE),
        .IWaitF     (IWaitF),
        .DWaitM     (DWaitM),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .FlushW     (FlushW),
        .ForwardAD  (ForwardAD),
        .ForwardBD  (ForwardBD),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MulDivBusy (MulDivBusy)
    );

    always #5 clk = ~clk;

    assign obs = {StallF, StallD, StallE, StallM, FlushE, FlushM, FlushW,
                  ForwardAD, ForwardBD, ForwardAE, ForwardBE, MulDivBusy};

    task automatic clr();
        RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
        WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; MemtoRegM = 1'b0;
        BranchD = 1'b0; MulDivE = 1'b0; IWaitF = 1'b0; DWaitM = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // st={F,D,E,M} stalls, fl={E,M,W} flushes, fd={AD,BD}
    task automatic chk(input string tag, input logic [3:0] st, input logic [2:0] fl,
                       input logic [1:0] fd, input logic [1:0] ae, input logic [1:0] be,
                       input logic busy);
        logic [13:0] e;
        string       t;
        exp_q.push_back({st, fl, fd, ae, be, busy});
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (StF D E M FlE M W FAD FBD FAE FBE busy)",
                   t, obs, e);
        end
    endtask

    initial begin
        reset = 1'b1;
        clr();
        chk("reset", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        MulDivE = 1'b1;
        chk("reset_md_masked", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        reset = 1'b0;

        // load-use
        clr(); MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd2; RsD = 5'd2;
        chk("lw_stall", 4'b1100, 3'b100, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        clr(); MemtoRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd2; RsD = 5'd2;
        chk("lw_bubble", 4'b0000, 3'b000, 2'b10, 2'b00, 2'b00, 1'b0);
        tick();
        clr(); RegWriteW = 1'b1; WriteRegW = 5'd2; RsE = 5'd2;
        chk("lw_fwd_w", 4'b0000, 3'b000, 2'b00, 2'b01, 2'b00, 1'b0);
        tick();

        // branch compare
        clr(); RegWriteM = 1'b1; WriteRegM = 5'd3; BranchD = 1'b1; RsD = 5'd3; RtD = 5'd5;
        chk("br_fwd_m", 4'b0000, 3'b000, 2'b10, 2'b00, 2'b00, 1'b0);
        tick();
        clr(); RegWriteE = 1'b1; WriteRegE = 5'd3; BranchD = 1'b1; RsD = 5'd3; RtD = 5'd5;
        chk("br_stall_e", 4'b1100, 3'b100, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        clr(); MemtoRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd5;
        BranchD = 1'b1; RsD = 5'd3; RtD = 5'd5;
        chk("br_stall_ld_m", 4'b1100, 3'b100, 2'b01, 2'b00, 2'b00, 1'b0);
        tick();
        clr(); RegWriteE = 1'b1; WriteRegE = 5'd3; RsD = 5'd3;
        chk("nobranch_nostall", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();

        // forwarding priority
        clr(); RegWriteM = 1'b1; WriteRegM = 5'd4; RegWriteW = 1'b1; WriteRegW = 5'd4;
        RsE = 5'd4; RtE = 5'd4;
        chk("fwd_m_over_w", 4'b0000, 3'b000, 2'b00, 2'b10, 2'b10, 1'b0);
        tick();
        clr(); WriteRegM = 5'd6; RegWriteW = 1'b1; WriteRegW = 5'd6; RsE = 5'd6; RtE = 5'd6;
        chk("fwd_w_when_m_nowrite", 4'b0000, 3'b000, 2'b00, 2'b01, 2'b01, 1'b0);
        tick();

        // register 0
        clr(); RegWriteM = 1'b1; RegWriteW = 1'b1;
        chk("r0_no_fwd", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        clr(); MemtoRegE = 1'b1; RegWriteE = 1'b1; BranchD = 1'b1;
        MemtoRegM = 1'b1; RegWriteM = 1'b1;
        chk("r0_no_stall", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();

        // mul/div, no memwait
        clr(); MulDivE = 1'b1;
        chk("md_c0", 4'b1110, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        chk("md_c1", 4'b1110, 3'b010, 2'b00, 2'b00, 2'b00, 1'b1);
        tick();
        chk("md_c2", 4'b1110, 3'b010, 2'b00, 2'b00, 2'b00, 1'b1);
        tick();
        chk("md_c3_advance", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b1);
        tick();
        MulDivE = 1'b0;
        chk("md_done", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        chk("md_idle", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();

        // data wait across BUSY and DONE
        clr(); MulDivE = 1'b1;
        chk("dw_c0", 4'b1110, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        DWaitM = 1'b1;
        chk("dw_c1", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        tick();
        chk("dw_c2", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        tick();
        chk("dw_c3", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        tick();
        chk("dw_c4_done", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        chk("dw_c5_done", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        DWaitM = 1'b0;
        chk("dw_no_restart", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        MulDivE = 1'b0;
        chk("dw_idle", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();

        // memwait beats load-use
        clr(); IWaitF = 1'b1; MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd2; RsD = 5'd2;
        chk("memwait_over_lw", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();

        // memwait in IDLE delays the start, then async reset aborts BUSY
        clr(); IWaitF = 1'b1; MulDivE = 1'b1;
        chk("iw_idle", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        IWaitF = 1'b0;
        chk("iw_no_start", 4'b1110, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        chk("rst_pre_busy", 4'b1110, 3'b010, 2'b00, 2'b00, 2'b00, 1'b1);
        reset = 1'b1;
        chk("rst_async", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        reset = 1'b0;
        chk("rst_c0", 4'b1110, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        chk("rst_c1", 4'b1110, 3'b010, 2'b00, 2'b00, 2'b00, 1'b1);
        tick();
        chk("rst_c2", 4'b1110, 3'b010, 2'b00, 2'b00, 2'b00, 1'b1);
        tick();
        chk("rst_c3", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b1);
        tick();
        MulDivE = 1'b0;
        chk("rst_done", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
